// File: rtl/ysyx_25030081_ifu.sv
// Instruction fetch unit: one outstanding valid/ready read between the core and instruction memory.
// Optional watchdog enabled by defining YSYX_25030081_IFU_TIMEOUT_EN.
module ysyx_25030081_ifu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    output logic                  fetch_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  flush,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  fault,
    output logic [1:0]            fault_cause
);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_HOLD = 2'b11
    } state_e;

    state_e                state_q, state_d;
    logic                  drop_q, drop_d;
    logic                  inst_valid_q, inst_valid_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  fault_q, fault_d;
    logic [1:0]            cause_q, cause_d;
    logic                  tmo_hit_s;
    logic                  accept_s;

`ifdef YSYX_25030081_IFU_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit_s = (tmo_cnt_q == CW'(TIMEOUT - 1));

    // Watchdog: counts REQ/WAIT cycles, restarts whenever the FSM passes through IDLE/HOLD or on flush.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (flush) begin
            tmo_cnt_d = {CW{1'b0}};
        end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
        end else begin
            tmo_cnt_d = {CW{1'b0}};
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt_q <= {CW{1'b0}};
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout_s;

    assign tmo_hit_s        = 1'b0;
    assign unused_timeout_s = (TIMEOUT > 0);
`endif

    assign fetch_ready = rst && (state_q == S_IDLE) && !flush;
    assign accept_s    = fetch_valid && fetch_ready;

    // Next-state and output-register logic for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        fault_d      = fault_q;
        cause_d      = cause_q;

        case (state_q)
            S_IDLE: begin
                // drop only survives here after a watchdog abort; the straggler response retires it
                if (drop_q && imem_rsp_valid) begin
                    drop_d = 1'b0;
                end else begin
                    drop_d = drop_q;
                end
                if (accept_s) begin
                    inst_pc_d = fetch_pc;
                    if (fetch_pc[1:0] != 2'b00) begin
                        state_d      = S_HOLD;
                        inst_valid_d = 1'b1;
                        inst_d       = {DATA_WIDTH{1'b0}};
                        fault_d      = 1'b1;
                        cause_d      = CAUSE_MISALIGN;
                    end else begin
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = fetch_pc;
                        fault_d     = 1'b0;
                        cause_d     = CAUSE_NONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (tmo_hit_s) begin
                    req_valid_d = 1'b0;
                    drop_d      = imem_req_ready;
                    if (flush || drop_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d      = S_HOLD;
                        inst_valid_d = 1'b1;
                        inst_d       = {DATA_WIDTH{1'b0}};
                        fault_d      = 1'b1;
                        cause_d      = CAUSE_TIMEOUT;
                    end
                end else if (imem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = S_WAIT;
                    drop_d      = drop_q || flush;
                end else begin
                    drop_d = drop_q || flush;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_q || flush) begin
                        state_d = S_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d      = S_HOLD;
                        inst_valid_d = 1'b1;
                        inst_d       = imem_rsp_err ? {DATA_WIDTH{1'b0}} : imem_rsp_data;
                        fault_d      = imem_rsp_err;
                        cause_d      = imem_rsp_err ? CAUSE_BUSERR : CAUSE_NONE;
                    end
                end else if (tmo_hit_s) begin
                    drop_d = 1'b1;
                    if (drop_q || flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d      = S_HOLD;
                        inst_valid_d = 1'b1;
                        inst_d       = {DATA_WIDTH{1'b0}};
                        fault_d      = 1'b1;
                        cause_d      = CAUSE_TIMEOUT;
                    end
                end else begin
                    drop_d = drop_q || flush;
                end
            end
            S_HOLD: begin
                if (drop_q && imem_rsp_valid) begin
                    drop_d = 1'b0;
                end else begin
                    drop_d = drop_q;
                end
                if (flush || inst_ready) begin
                    state_d      = S_IDLE;
                    inst_valid_d = 1'b0;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d      = S_IDLE;
                drop_d       = 1'b0;
                inst_valid_d = 1'b0;
                req_valid_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= {DATA_WIDTH{1'b0}};
            inst_pc_q    <= {ADDR_WIDTH{1'b0}};
            req_valid_q  <= 1'b0;
            req_addr_q   <= {ADDR_WIDTH{1'b0}};
            fault_q      <= 1'b0;
            cause_q      <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            fault_q      <= fault_d;
            cause_q      <= cause_d;
        end
    end

    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign fault          = fault_q;
    assign fault_cause    = cause_q;

endmodule

// File: tb/tb_ysyx_25030081_ifu.sv
// Bench for ysyx_25030081_ifu: transaction-level reference model plus memory responder,
// directed scenarios followed by randomized traffic.
module tb_ysyx_25030081_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        fault;
    logic [1:0]  fault_cause;

    always #5 clk = ~clk;

    ysyx_25030081_ifu #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_pc      (fetch_pc),
        .flush         (flush),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .fault         (fault),
        .fault_cause   (fault_cause)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level view: request pending, response pending, beat visible, transaction still wanted.
    bit          m_req, m_rsp, m_beat, m_live;
    logic [31:0] m_pc, m_addr, e_inst;
    bit          e_fault;
    logic [1:0]  e_cause;

    // Memory responder knobs and state.
    bit          random_mode = 1'b0;
    bit          model_en    = 1'b1;
    int          p_spur      = 0;
    int          rdy_low     = 0;
    int          next_delay  = 0;
    logic [31:0] next_data   = 32'h0;
    bit          next_err    = 1'b0;
    int          rsp_wait    = 0;
    logic [31:0] rsp_data_q  = 32'h0;
    bit          rsp_err_q   = 1'b0;
    int          req_count   = 0;
    bit          obs_valid;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req  = 1'b0;
        m_rsp  = 1'b0;
        m_beat = 1'b0;
        m_live = 1'b0;
    endtask

    // One clock: check registered outputs, drive inputs, check fetch_ready, advance the model.
    task automatic cycle(input bit rs, input bit fv, input logic [31:0] pc, input bit fl, input bit ir);
        bit idle, e_ready, acc, hs, rsp, cons;
        @(negedge clk);
        obs_valid = inst_valid;
        if (model_en) begin
            check_eq("inst_valid", inst_valid, m_beat);
            check_eq("req_valid", imem_req_valid, m_req);
            if (m_req) check_eq("req_addr", imem_req_addr, m_addr);
            if (m_beat) begin
                check_eq("inst", inst, e_inst);
                check_eq("inst_pc", inst_pc, m_pc);
                check_eq("fault", fault, e_fault);
                check_eq("fault_cause", fault_cause, e_cause);
            end
        end
        rst         = rs;
        fetch_valid = fv;
        fetch_pc    = pc;
        flush       = fl;
        inst_ready  = ir;
        if (random_mode) begin
            imem_req_ready = 1'($urandom_range(0, 1));
        end else if (m_req && rdy_low > 0) begin
            imem_req_ready = 1'b0;
            rdy_low--;
        end else begin
            imem_req_ready = m_req;
        end
        if (m_rsp) begin
            imem_rsp_valid = (rsp_wait == 0);
            imem_rsp_data  = rsp_data_q;
            imem_rsp_err   = rsp_err_q;
        end else if (int'($urandom_range(0, 99)) < p_spur) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = 1'($urandom_range(0, 1));
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = 1'b0;
        end
        #1;
        idle    = !m_req && !m_rsp && !m_beat;
        e_ready = rs && idle && !fl;
        if (model_en) check_eq("fetch_ready", fetch_ready, e_ready);
        if (!rs) begin
            model_reset();
        end else begin
            acc  = fv && e_ready;
            hs   = m_req && imem_req_ready;
            rsp  = m_rsp && imem_rsp_valid;
            cons = m_beat && ir && !fl;
            if (m_rsp && !rsp) rsp_wait--;
            if (rsp) begin
                m_rsp = 1'b0;
                if (m_live && !fl) begin
                    m_beat  = 1'b1;
                    e_inst  = rsp_err_q ? 32'h0 : rsp_data_q;
                    e_fault = rsp_err_q;
                    e_cause = rsp_err_q ? 2'b10 : 2'b00;
                end
            end
            if (hs) begin
                m_req = 1'b0;
                m_rsp = 1'b1;
                req_count++;
                if (random_mode) begin
                    rsp_wait   = $urandom_range(0, 4);
                    rsp_data_q = $urandom;
                    rsp_err_q  = ($urandom_range(0, 7) == 0);
                end else begin
                    rsp_wait   = next_delay;
                    rsp_data_q = next_data;
                    rsp_err_q  = next_err;
                end
            end
            if (cons) begin
                m_beat = 1'b0;
                m_live = 1'b0;
            end
            if (fl) begin
                m_beat = 1'b0;
                m_live = 1'b0;
            end
            if (acc) begin
                m_live = 1'b1;
                m_pc   = pc;
                if (pc[1:0] != 2'b00) begin
                    m_beat  = 1'b1;
                    e_inst  = 32'h0;
                    e_fault = 1'b1;
                    e_cause = 2'b01;
                end else begin
                    m_req  = 1'b1;
                    m_addr = pc;
                end
            end
        end
    endtask

    // Idle cycles until a beat is seen; n is the cycle index after the accept (0 if none within maxc).
    task automatic wait_beat(input int maxc, output int n);
        n = 0;
        for (int i = 1; i <= maxc; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            if (obs_valid) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int rc0;
    bit          r_fv, r_fl, r_ir;
    logic [31:0] r_pc;

    initial begin
        rst            = 1'b0;
        fetch_valid    = 1'b0;
        fetch_pc       = 32'h0;
        flush          = 1'b0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state and fetch_ready held low during reset
        cycle(1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        check_eq("rst_fetch_ready", fetch_ready, 1'b0);
        check_eq("rst_inst_valid", inst_valid, 1'b0);
        check_eq("rst_req_valid", imem_req_valid, 1'b0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_inst_pc", inst_pc, 32'h0);
        check_eq("rst_req_addr", imem_req_addr, 32'h0);
        check_eq("rst_fault", fault, 1'b0);
        check_eq("rst_cause", fault_cause, 2'b00);

        // Zero-wait fetch
        next_delay = 0; next_data = 32'h0010_0073; next_err = 1'b0;
        cycle(1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        wait_beat(20, n);
        check_eq("zw_latency", n, 3);
        check_eq("zw_inst", inst, 32'h0010_0073);
        check_eq("zw_pc", inst_pc, 32'h8000_0000);
        check_eq("zw_fault", fault, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        // Misaligned PC: immediate fault, no bus request
        rc0 = req_count;
        cycle(1'b1, 1'b1, 32'h8000_0002, 1'b0, 1'b0);
        wait_beat(5, n);
        check_eq("mis_latency", n, 1);
        check_eq("mis_fault", fault, 1'b1);
        check_eq("mis_cause", fault_cause, 2'b01);
        check_eq("mis_inst", inst, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("mis_noreq", req_count, rc0);

        // Bus error response
        next_data = 32'hcafe_f00d; next_err = 1'b1; next_delay = 1;
        cycle(1'b1, 1'b1, 32'h8000_0010, 1'b0, 1'b0);
        wait_beat(20, n);
        check_eq("err_fault", fault, 1'b1);
        check_eq("err_cause", fault_cause, 2'b10);
        check_eq("err_inst", inst, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        next_err = 1'b0;

        // Backpressure on request, response and consume
        rc0 = req_count; rdy_low = 4; next_delay = 5; next_data = 32'h1234_5013;
        cycle(1'b1, 1'b1, 32'h8000_0008, 1'b0, 1'b0);
        wait_beat(40, n);
        check_eq("bp_seen", (n > 0), 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("bp_inst", inst, 32'h1234_5013);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("bp_one_req", req_count - rc0, 1);

        // Flush while waiting, then a fresh fetch returns its own data
        next_delay = 3; next_data = 32'hdead_beef;
        cycle(1'b1, 1'b1, 32'h8000_000c, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        wait_beat(10, n);
        check_eq("fl_no_beat", n, 0);
        next_delay = 0; next_data = 32'h0041_0113;
        cycle(1'b1, 1'b1, 32'h8000_0004, 1'b0, 1'b0);
        wait_beat(20, n);
        check_eq("fl_next_latency", n, 3);
        check_eq("fl_next_inst", inst, 32'h0041_0113);
        check_eq("fl_next_pc", inst_pc, 32'h8000_0004);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        // Reset mid-transaction, stale response afterwards is ignored
        next_delay = 3;
        cycle(1'b1, 1'b1, 32'h8000_0020, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        p_spur = 100;
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("mrst_inst_pc", inst_pc, 32'h0);
        check_eq("mrst_req_addr", imem_req_addr, 32'h0);
        p_spur = 0;
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Randomized traffic
        random_mode = 1'b1; p_spur = 10;
        for (int i = 0; i < 3000; i++) begin
            r_fv = ($urandom_range(0, 2) != 0);
            r_fl = ($urandom_range(0, 19) == 0);
            r_ir = r_fl ? 1'b0 : 1'($urandom_range(0, 1));
            r_pc = $urandom;
            r_pc[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle(1'b1, r_fv, r_pc, r_fl, r_ir);
        end
        random_mode = 1'b0; p_spur = 0;
        repeat (12) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        // Memory that never answers
        rc0 = req_count; next_delay = 5000; next_data = 32'h0000_0013;
`ifdef YSYX_25030081_IFU_TIMEOUT_EN
        model_en = 1'b0;
        cycle(1'b1, 1'b1, 32'h8000_0040, 1'b0, 1'b0);
        wait_beat(40, n);
        check_eq("tmo_latency", n, 17);
        check_eq("tmo_fault", fault, 1'b1);
        check_eq("tmo_cause", fault_cause, 2'b11);
        check_eq("tmo_inst", inst, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        rsp_wait = 0;
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("tmo_late_ignored", inst_valid, 1'b0);
        check_eq("tmo_idle", fetch_ready, 1'b1);
`else
        cycle(1'b1, 1'b1, 32'h8000_0040, 1'b0, 1'b0);
        wait_beat(1000, n);
        check_eq("nowd_still_waiting", n, 0);
        check_eq("nowd_busy", fetch_ready, 1'b0);
        check_eq("nowd_one_req", req_count - rc0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
